// File: rtl/display_scan_ctrl.sv
// Scan controller for a 4-digit multiplexed display: steps sel through digits 0..3
// with a blanking guard per slot, tear-free shadowed digit values and leading-zero blanking.
module display_scan_ctrl #(
  parameter int CLK_DIV   = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_in,
  input  logic        lz_blank,
  output logic [1:0]  sel,
  output logic        en_out,
  output logic [3:0]  nibble,
  output logic        dp,
  output logic        frame_tick
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      sh_digits;
  logic [3:0]       sh_dp;
  logic [1:0]       sel_nxt;
  logic             sup_cur;

  assign sel_nxt = sel + 2'd1;

  // Suppression looks at the shadowed frame values so it never tears mid-frame.
  always_comb begin
    sup_cur = 1'b0;
    if (lz_blank) begin
      case (sel)
        2'd3:    sup_cur = (sh_digits[15:12] == 4'd0);
        2'd2:    sup_cur = (sh_digits[15:8] == 8'd0);
        2'd1:    sup_cur = (sh_digits[15:4] == 12'd0);
        default: sup_cur = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      sh_digits  <= '0;
      sh_dp      <= '0;
      sel        <= '0;
      en_out     <= 1'b0;
      nibble     <= '0;
      dp         <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      if (!enable) begin
        state  <= IDLE;
        cnt    <= '0;
        sel    <= '0;
        en_out <= 1'b0;
        nibble <= '0;
        dp     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state     <= BLANK;
            cnt       <= '0;
            sel       <= '0;
            en_out    <= 1'b0;
            sh_digits <= digits;
            sh_dp     <= dp_in;
            nibble    <= digits[3:0];
            dp        <= dp_in[0];
          end
          BLANK: begin
            cnt <= cnt + 1'b1;
            if (cnt == BLANK_LAST) begin
              state  <= SHOW;
              en_out <= !sup_cur;
            end
          end
          SHOW: begin
            if (cnt == SHOW_LAST) begin
              cnt    <= '0;
              state  <= BLANK;
              en_out <= 1'b0;
              sel    <= sel_nxt;
              // On the frame wrap the shadow is loaded in the same edge, so digit0 comes straight from the inputs.
              if (sel == 2'd3) begin
                frame_tick <= 1'b1;
                sh_digits  <= digits;
                sh_dp      <= dp_in;
                nibble     <= digits[3:0];
                dp         <= dp_in[0];
              end else begin
                nibble <= sh_digits[{sel_nxt, 2'b00} +: 4];
                dp     <= sh_dp[sel_nxt];
              end
            end else begin
              cnt    <= cnt + 1'b1;
              en_out <= !sup_cur;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with CLK_DIV=8, BLANK_CYC=2.
module tb_display_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] digits = '0;
  logic [3:0]  dp_in = '0;
  logic        lz_blank = 1'b0;
  logic [1:0]  sel;
  logic        en_out;
  logic [3:0]  nibble;
  logic        dp;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;

  display_scan_ctrl #(.CLK_DIV(8), .BLANK_CYC(2)) dut (
    .clk(clk), .rst(rst), .enable(enable), .digits(digits), .dp_in(dp_in),
    .lz_blank(lz_blank), .sel(sel), .en_out(en_out), .nibble(nibble), .dp(dp),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] digits;
    logic [3:0]  dp_in;
    logic        lz;
    logic [15:0] exp_nib;  // expected nibble for sel=i at [4i+3:4i]
    logic [3:0]  exp_dp;
    logic [3:0]  exp_lit;  // 1 = digit i lit during SHOW
  } vec_t;

  vec_t vecs[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int t, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s t=%0d actual=%0h required=%0h", name, t, act, req);
    end
  endtask

  // t counts cycles since the first BLANK cycle of a scan started from IDLE.
  task automatic check_slot(input string name, input int t, input logic [15:0] enib,
                            input logic [3:0] edp, input logic [3:0] elit);
    int s;
    int pos;
    logic [15:0] nib_v;
    s = (t / 8) % 4;
    pos = t % 8;
    nib_v = enib;
    chk({name, ".sel"}, t, 32'(sel), 32'(s));
    chk({name, ".en_out"}, t, 32'(en_out), 32'((pos >= 2) && elit[s]));
    chk({name, ".nibble"}, t, 32'(nibble), 32'(nib_v[s*4 +: 4]));
    chk({name, ".dp"}, t, 32'(dp), 32'(edp[s]));
    chk({name, ".frame_tick"}, t, 32'(frame_tick), 32'((t % 32 == 0) && (t != 0)));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic check_zero(input string name, input int t);
    chk({name, ".sel"}, t, 32'(sel), 32'd0);
    chk({name, ".en_out"}, t, 32'(en_out), 32'd0);
    chk({name, ".nibble"}, t, 32'(nibble), 32'd0);
    chk({name, ".dp"}, t, 32'(dp), 32'd0);
    chk({name, ".frame_tick"}, t, 32'(frame_tick), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{"basic_1234", 16'h1234, 4'b0000, 1'b0, 16'h1234, 4'b0000, 4'b1111};
    vecs[1] = '{"lz_0005",    16'h0005, 4'b0000, 1'b1, 16'h0005, 4'b0000, 4'b0001};
    vecs[2] = '{"nolz_0005",  16'h0005, 4'b0000, 1'b0, 16'h0005, 4'b0000, 4'b1111};
    vecs[3] = '{"lz_00a0",    16'h00A0, 4'b0101, 1'b1, 16'h00A0, 4'b0101, 4'b0011};
    vecs[4] = '{"lz_0000",    16'h0000, 4'b0010, 1'b1, 16'h0000, 4'b0010, 4'b0001};
    vecs[5] = '{"lz_f00f",    16'hF00F, 4'b1000, 1'b1, 16'hF00F, 4'b1000, 4'b1111};

    // Reset state
    #1;
    check_zero("reset", 0);
    do_reset();
    check_zero("idle", 0);

    // Table-driven: two full frames per vector
    foreach (vecs[i]) begin
      do_reset();
      digits = vecs[i].digits;
      dp_in = vecs[i].dp_in;
      lz_blank = vecs[i].lz;
      enable = 1'b1;
      for (int t = 0; t < 64; t++) begin
        step();
        check_slot(vecs[i].name, t, vecs[i].exp_nib, vecs[i].exp_dp, vecs[i].exp_lit);
      end
    end

    // Three frames: frame_tick only on the 3->0 wraps
    do_reset();
    digits = 16'h1234; dp_in = 4'b0000; lz_blank = 1'b0; enable = 1'b1;
    for (int t = 0; t < 97; t++) begin
      step();
      check_slot("three_frames", t, 16'h1234, 4'b0000, 4'b1111);
    end

    // Tear-free: change digits during sel=1 SHOW
    do_reset();
    digits = 16'hAAAA; enable = 1'b1;
    for (int t = 0; t < 64; t++) begin
      step();
      check_slot("tear", t, (t < 32) ? 16'hAAAA : 16'h5555, 4'b0000, 4'b1111);
      if (t == 11) digits = 16'h5555;
    end

    // Drop enable during sel=2 SHOW, then re-enable
    do_reset();
    digits = 16'h1234; enable = 1'b1;
    for (int t = 0; t <= 20; t++) begin
      step();
      check_slot("pre_drop", t, 16'h1234, 4'b0000, 4'b1111);
    end
    enable = 1'b0;
    step();
    chk("drop.sel", 0, 32'(sel), 32'd0);
    chk("drop.en_out", 0, 32'(en_out), 32'd0);
    chk("drop.frame_tick", 0, 32'(frame_tick), 32'd0);
    enable = 1'b1;
    for (int t = 0; t < 10; t++) begin
      step();
      check_slot("reenable", t, 16'h1234, 4'b0000, 4'b1111);
    end

    // Asynchronous reset mid-SHOW on sel=3
    do_reset();
    digits = 16'h1234; enable = 1'b1;
    for (int t = 0; t <= 28; t++) begin
      step();
      check_slot("pre_rst", t, 16'h1234, 4'b0000, 4'b1111);
    end
    rst = 1'b1;
    #1;
    check_zero("async_rst", 0);
    for (int k = 1; k <= 4; k++) begin
      step();
      check_zero("rst_hold", k);
    end
    rst = 1'b0;
    for (int t = 0; t < 40; t++) begin
      step();
      check_slot("post_rst", t, 16'h1234, 4'b0000, 4'b1111);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
